// File: rtl/console_pkg.sv
// Shared types and widths for the console I/O sequencer.
package console_pkg;

    localparam int unsigned CONSOLE_DATA_W    = 10;
    localparam int unsigned CONSOLE_OUT_DEPTH = 4;

    // Sequencer FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_OUT_FULL   = 3'd1,
        ST_IN_FLUSH   = 3'd2,
        ST_IN_WAIT    = 3'd3,
        ST_IN_RELEASE = 3'd4,
        ST_DONE       = 3'd5
    } console_state_t;

endpackage

// File: rtl/console_out_fifo.sv
// Synchronous output-character FIFO.
// Ports: Clk/Rst_n; i_push+i_wdata write; i_pop removes o_head;
//        o_full/o_empty/o_count status. Push while full is accepted only
//        together with a pop in the same cycle.
module console_out_fifo #(
    parameter int unsigned DataSize = 10,
    parameter int unsigned OutDepth = 4
) (
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic                             i_push,
    input  logic [DataSize-1:0]              i_wdata,
    input  logic                             i_pop,
    output logic [DataSize-1:0]              o_head,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [$clog2(OutDepth+1)-1:0]    o_count
);

    localparam int unsigned PW = $clog2(OutDepth);
    localparam int unsigned CW = $clog2(OutDepth + 1);

    logic [DataSize-1:0] r_mem [OutDepth];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(OutDepth));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage: no reset needed, occupancy is tracked by r_count
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/console_io_sequencer.sv
// Sequences CPU console read/write instructions onto ConsoleIn/ConsoleOut.
// Outgoing characters are buffered and drained at the ConsoleOut pace; a read
// is only served once every buffered character has been written.
// Ports: Clk/Rst_n; cpu_* request/response towards the instruction sequencer;
//        con_in_* ConsoleIn handshake; con_out_* ConsoleOut strobe;
//        out_level FIFO occupancy; in_waiting blocked on ConsoleIn.
module console_io_sequencer
    import console_pkg::*;
#(
    parameter int unsigned DataSize = CONSOLE_DATA_W,
    parameter int unsigned OutDepth = CONSOLE_OUT_DEPTH
) (
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic                             cpu_in_req,
    input  logic                             cpu_out_req,
    input  logic [DataSize-1:0]              cpu_out_data,
    output logic                             cpu_done,
    output logic [DataSize-1:0]              cpu_in_data,
    input  logic                             con_in_ready,
    input  logic [DataSize-1:0]              con_in_data,
    output logic                             con_in_ack,
    input  logic                             con_out_busy,
    output logic                             con_out_write,
    output logic [DataSize-1:0]              con_out_data,
    output logic [$clog2(OutDepth+1)-1:0]    out_level,
    output logic                             in_waiting
);

    localparam int unsigned LW = $clog2(OutDepth + 1);

    console_state_t      r_state;
    console_state_t      w_next_state;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_done_set;
    logic                w_ack_set;
    logic [DataSize-1:0] w_head;
    logic [LW-1:0]       w_count;

    logic                r_cpu_done;
    logic                r_con_in_ack;
    logic                r_con_out_write;
    logic                r_in_waiting;
    logic [DataSize-1:0] r_cpu_in_data;
    logic [DataSize-1:0] r_con_out_data;

    // Drain: one write at most every other cycle so busy has a cycle to rise
    assign w_pop = !w_empty && !con_out_busy && !r_con_out_write;

    console_out_fifo #(
        .DataSize (DataSize),
        .OutDepth (OutDepth)
    ) u_out_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_push  (w_push),
        .i_wdata (cpu_out_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and one-cycle action decisions
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_done_set   = 1'b0;
        w_ack_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Output has priority; a concurrent read stays pending
                if (cpu_out_req) begin
                    if (!w_full) begin
                        w_push       = 1'b1;
                        w_done_set   = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_OUT_FULL;
                    end
                end else if (cpu_in_req) begin
                    w_next_state = ST_IN_FLUSH;
                end
            end
            ST_OUT_FULL: begin
                if (!cpu_out_req) begin
                    w_next_state = ST_IDLE;
                end else if (!w_full || w_pop) begin
                    w_push       = 1'b1;
                    w_done_set   = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_IN_FLUSH: begin
                // Prompt first: FIFO empty and last strobe already out
                if (!cpu_in_req) begin
                    w_next_state = ST_IDLE;
                end else if (w_empty && !r_con_out_write) begin
                    w_next_state = ST_IN_WAIT;
                end
            end
            ST_IN_WAIT: begin
                if (!cpu_in_req) begin
                    w_next_state = ST_IDLE;
                end else if (con_in_ready) begin
                    w_ack_set    = 1'b1;
                    w_done_set   = 1'b1;
                    w_next_state = ST_IN_RELEASE;
                end
            end
            ST_IN_RELEASE: begin
                // A held ready level must not trigger another read
                if (!con_in_ready) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cpu_done      <= 1'b0;
            r_con_in_ack    <= 1'b0;
            r_con_out_write <= 1'b0;
            r_in_waiting    <= 1'b0;
            r_cpu_in_data   <= '0;
            r_con_out_data  <= '0;
        end else begin
            r_cpu_done      <= w_done_set;
            r_con_in_ack    <= w_ack_set;
            r_con_out_write <= w_pop;
            r_in_waiting    <= (w_next_state == ST_IN_WAIT);
            if (w_ack_set) r_cpu_in_data  <= con_in_data;
            if (w_pop)     r_con_out_data <= w_head;
        end
    end

    assign cpu_done      = r_cpu_done;
    assign cpu_in_data   = r_cpu_in_data;
    assign con_in_ack    = r_con_in_ack;
    assign con_out_write = r_con_out_write;
    assign con_out_data  = r_con_out_data;
    assign in_waiting    = r_in_waiting;
    assign out_level     = w_count;

endmodule

// File: tb/tb_console_io_sequencer.sv
// Self-checking bench for console_io_sequencer: output characters go into a
// scoreboard queue when requested and are compared as ConsoleOut strobes appear.
module tb_console_io_sequencer;

    localparam int unsigned DW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          cpu_in_req = 1'b0;
    logic          cpu_out_req = 1'b0;
    logic [DW-1:0] cpu_out_data = '0;
    logic          cpu_done;
    logic [DW-1:0] cpu_in_data;
    logic          con_in_ready = 1'b0;
    logic [DW-1:0] con_in_data = '0;
    logic          con_in_ack;
    logic          con_out_busy = 1'b0;
    logic          con_out_write;
    logic [DW-1:0] con_out_data;
    logic [LW-1:0] out_level;
    logic          in_waiting;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] mon_exp;
    logic          prev_write = 1'b0;

    console_io_sequencer #(.DataSize(DW), .OutDepth(DEPTH)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .cpu_in_req    (cpu_in_req),
        .cpu_out_req   (cpu_out_req),
        .cpu_out_data  (cpu_out_data),
        .cpu_done      (cpu_done),
        .cpu_in_data   (cpu_in_data),
        .con_in_ready  (con_in_ready),
        .con_in_data   (con_in_data),
        .con_in_ack    (con_in_ack),
        .con_out_busy  (con_out_busy),
        .con_out_write (con_out_write),
        .con_out_data  (con_out_data),
        .out_level     (out_level),
        .in_waiting    (in_waiting)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ConsoleOut monitor: order, data and write spacing
    always @(negedge Clk) begin
        if (Rst_n && con_out_write) begin
            check_eq("wr_b2b", 32'(prev_write), 32'd0);
            check_eq("wr_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check_eq("wr_data", 32'(con_out_data), 32'(mon_exp));
            end
        end
        prev_write = Rst_n && con_out_write;
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_done"},  32'(cpu_done), 32'd0);
        check_eq({tag, "_indat"}, 32'(cpu_in_data), 32'd0);
        check_eq({tag, "_ack"},   32'(con_in_ack), 32'd0);
        check_eq({tag, "_wr"},    32'(con_out_write), 32'd0);
        check_eq({tag, "_odat"},  32'(con_out_data), 32'd0);
        check_eq({tag, "_lvl"},   32'(out_level), 32'd0);
        check_eq({tag, "_wait"},  32'(in_waiting), 32'd0);
    endtask

    // One output request; expects cpu_done exactly one cycle after acceptance
    task automatic do_out(input logic [DW-1:0] d, input string tag);
        int cyc;
        cyc = 0;
        cpu_out_req  = 1'b1;
        cpu_out_data = d;
        sb_q.push_back(d);
        do begin
            @(negedge Clk);
            cyc++;
        end while (!cpu_done && cyc < 20);
        check_eq(tag, 32'(cyc), 32'd1);
        cpu_out_req  = 1'b0;
        cpu_out_data = '0;
        @(negedge Clk);
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || out_level != 0) && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        @(negedge Clk);
        check_eq({tag, "_lvl"}, 32'(out_level), 32'd0);
        check_eq({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Wait for an input ack; returns whether a write or in_waiting was seen before it
    task automatic wait_ack(output logic seen, output logic wrote, output logic waited);
        int cyc;
        cyc    = 0;
        wrote  = 1'b0;
        waited = 1'b0;
        do begin
            @(negedge Clk);
            cyc++;
            if (!con_in_ack) begin
                wrote  = wrote | con_out_write;
                waited = waited | in_waiting;
            end
        end while (!con_in_ack && cyc < 40);
        seen = con_in_ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen, wrote, waited, saw;
        int   cnt, cyc;

        // Reset state
        repeat (2) @(negedge Clk);
        check_all_zero("rst");
        Rst_n = 1'b1;
        @(negedge Clk);
        check_eq("rel_wr", 32'(con_out_write), 32'd0);

        // Out burst with ConsoleOut ready
        con_out_busy = 1'b0;
        do_out(10'h041, "burst0_lat");
        do_out(10'h042, "burst1_lat");
        do_out(10'h043, "burst2_lat");
        wait_drain("burst");

        // FIFO full: four accepted, fifth stalls until a slot frees
        con_out_busy = 1'b1;
        for (int i = 0; i < 4; i++) do_out(10'h100 + 10'(i), "full_lat");
        check_eq("full_lvl", 32'(out_level), 32'd4);
        cpu_out_req  = 1'b1;
        cpu_out_data = 10'h104;
        sb_q.push_back(10'h104);
        saw = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            saw = saw | cpu_done;
        end
        check_eq("full_stall", 32'(saw), 32'd0);
        check_eq("full_lvl_stall", 32'(out_level), 32'd4);
        con_out_busy = 1'b0;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!cpu_done && cyc < 20);
        check_eq("full_done", 32'(cpu_done), 32'd1);
        check_eq("full_done_with_pop", 32'(con_out_write), 32'd1);
        check_eq("full_lvl_swap", 32'(out_level), 32'd4);
        cpu_out_req = 1'b0;
        @(negedge Clk);
        wait_drain("full");

        // Read after write: prompt must be written before the read is served
        con_out_busy = 1'b1;
        do_out(10'h030, "raw_lat");
        con_in_ready = 1'b1;
        con_in_data  = 10'h155;
        cpu_in_req   = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            saw = saw | con_in_ack | in_waiting;
        end
        check_eq("raw_blocked", 32'(saw), 32'd0);
        con_out_busy = 1'b0;
        wait_ack(seen, wrote, waited);
        check_eq("raw_ack", 32'(seen), 32'd1);
        check_eq("raw_done", 32'(cpu_done), 32'd1);
        check_eq("raw_data", 32'(cpu_in_data), 32'h155);
        check_eq("raw_wrote_first", 32'(wrote), 32'd1);
        check_eq("raw_waited", 32'(waited), 32'd1);
        cpu_in_req = 1'b0;

        // Held ready: no further ack while the level stays high
        cnt = 0;
        repeat (3) begin
            @(negedge Clk);
            cnt += int'(con_in_ack) + int'(cpu_done);
        end
        check_eq("held_none", 32'(cnt), 32'd0);
        cpu_in_req = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge Clk);
            cnt += int'(con_in_ack);
        end
        check_eq("held_newreq_none", 32'(cnt), 32'd0);
        check_eq("held_data_kept", 32'(cpu_in_data), 32'h155);
        con_in_ready = 1'b0;
        con_in_data  = 10'h2AA;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!in_waiting && cyc < 20);
        check_eq("held_rewait", 32'(in_waiting), 32'd1);
        con_in_ready = 1'b1;
        wait_ack(seen, wrote, waited);
        check_eq("held_ack2", 32'(seen), 32'd1);
        check_eq("held_data2", 32'(cpu_in_data), 32'h2AA);
        cpu_in_req   = 1'b0;
        con_in_ready = 1'b0;
        repeat (3) @(negedge Clk);

        // Simultaneous requests: output first, read after DONE
        cpu_out_req  = 1'b1;
        cpu_out_data = 10'h07E;
        cpu_in_req   = 1'b1;
        sb_q.push_back(10'h07E);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!cpu_done && cyc < 20);
        check_eq("sim_out_lat", 32'(cyc), 32'd1);
        check_eq("sim_no_ack", 32'(con_in_ack), 32'd0);
        check_eq("sim_not_waiting", 32'(in_waiting), 32'd0);
        cpu_out_req = 1'b0;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!in_waiting && cyc < 20);
        check_eq("sim_waiting", 32'(in_waiting), 32'd1);
        check_eq("sim_written", 32'(sb_q.size()), 32'd0);
        con_in_ready = 1'b1;
        con_in_data  = 10'h111;
        wait_ack(seen, wrote, waited);
        check_eq("sim_ack", 32'(seen), 32'd1);
        check_eq("sim_data", 32'(cpu_in_data), 32'h111);
        cpu_in_req   = 1'b0;
        con_in_ready = 1'b0;
        repeat (3) @(negedge Clk);

        // Asynchronous reset with buffered characters and a pending read
        con_out_busy = 1'b1;
        do_out(10'h0A1, "rstb0_lat");
        do_out(10'h0A2, "rstb1_lat");
        check_eq("rstb_lvl", 32'(out_level), 32'd2);
        cpu_in_req = 1'b1;
        repeat (3) @(negedge Clk);
        check_eq("rstb_flushing", 32'(in_waiting), 32'd0);
        #2;
        Rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb_q.delete();
        cpu_in_req   = 1'b0;
        con_out_busy = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge Clk);
            cnt += int'(con_out_write);
        end
        check_eq("rst_no_wr", 32'(cnt), 32'd0);
        check_eq("rst_lvl", 32'(out_level), 32'd0);

        // Still functional after reset
        do_out(10'h05A, "post_rst_lat");
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
